// File: rtl/e_mdu_seq.sv
// E-stage multiply/divide unit: owns HI/LO and sequences multi-cycle mult/div
// behind a registered Busy, with combinational mfhi/mflo and IDLE-only mthi/mtlo.
module e_mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic [31:0] MDUIn1,
  input  logic [31:0] MDUIn2,
  output logic        Busy,
  output logic [31:0] MDURes
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic { S_IDLE = 1'b0, S_BUSY = 1'b1 } state_t;

  state_t                     r_state;
  logic        [CNT_W-1:0]    r_cnt;
  logic                       r_busy;
  logic        [DATA_W-1:0]   r_hi;
  logic        [DATA_W-1:0]   r_lo;
  logic        [DATA_W-1:0]   r_hi_t;
  logic        [DATA_W-1:0]   r_lo_t;
  logic                       r_upd;

  logic                       w_launch;
  logic                       w_is_div;
  logic                       w_sgn;
  logic        [2*DATA_W-1:0] w_mul;
  logic        [2*DATA_W-1:0] w_div;

  // Low 2W bits of the product of the W-bit operands, sign- or zero-extended.
  function automatic logic [2*DATA_W-1:0] f_mul(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sgn);
    logic [2*DATA_W-1:0] ea;
    logic [2*DATA_W-1:0] eb;
    ea = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    eb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  // Magnitude division with sign fix-up: {remainder, quotient}. The most
  // negative dividend over -1 wraps back to itself with zero remainder.
  function automatic logic [2*DATA_W-1:0] f_div(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sgn);
    logic              na;
    logic              nb;
    logic [DATA_W-1:0] ma;
    logic [DATA_W-1:0] mb;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    na = sgn & a[DATA_W-1];
    nb = sgn & b[DATA_W-1];
    ma = na ? (~a + 1'b1) : a;
    mb = nb ? (~b + 1'b1) : b;
    if (mb == '0) mb = {{(DATA_W-1){1'b0}}, 1'b1};
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = ~q + 1'b1;
    if (na)      r = ~r + 1'b1;
    return {r, q};
  endfunction

  assign w_launch = Start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
  assign w_is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  assign w_sgn    = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
  assign w_mul    = f_mul(MDUIn1, MDUIn2, w_sgn);
  assign w_div    = f_div(MDUIn1, MDUIn2, w_sgn);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
            r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (MDUOp == OP_MTHI) begin
            r_hi <= MDUIn1;
          end else if (MDUOp == OP_MTLO) begin
            r_lo <= MDUIn1;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          // Commit on the last Busy cycle; a zero divisor leaves HI/LO intact.
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (r_upd) begin
              r_hi <= r_hi_t;
              r_lo <= r_lo_t;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result staging is data only; it is qualified by the control state above.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_launch) begin
      r_upd <= !(w_is_div && (MDUIn2 == '0));
      if (w_is_div) begin
        r_hi_t <= w_div[2*DATA_W-1:DATA_W];
        r_lo_t <= w_div[DATA_W-1:0];
      end else begin
        r_hi_t <= w_mul[2*DATA_W-1:DATA_W];
        r_lo_t <= w_mul[DATA_W-1:0];
      end
    end
  end

  assign Busy = r_busy;

  always_comb begin
    MDURes = '0;
    if (MDUOp == OP_MFHI)      MDURes = r_hi;
    else if (MDUOp == OP_MFLO) MDURes = r_lo;
  end

endmodule

// File: tb/tb_e_mdu_seq.sv
// Directed bench for e_mdu_seq: Busy window length, HI/LO results and the
// ignore/abort corner cases, against hand-computed values.
module tb_e_mdu_seq;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic [31:0] MDUIn1;
  logic [31:0] MDUIn2;
  logic        Busy;
  logic [31:0] MDURes;

  int n_vec = 0;
  int n_err = 0;

  e_mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .MDUOp  (MDUOp),
    .Start  (Start),
    .MDUIn1 (MDUIn1),
    .MDUIn2 (MDUIn2),
    .Busy   (Busy),
    .MDURes (MDURes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    MDUOp = 4'd5; #1;
    chk({tag, ".hi"}, MDURes, hi);
    MDUOp = 4'd6; #1;
    chk({tag, ".lo"}, MDURes, lo);
    MDUOp = 4'd0; #1;
  endtask

  // Launch, then check Busy high for exactly n cycles and low afterwards.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n);
    MDUOp = op; Start = 1'b1; MDUIn1 = a; MDUIn2 = b;
    step();
    MDUOp = 4'd0; Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".busy"}, {31'd0, Busy}, 32'd1);
      step();
    end
    chk({tag, ".done"}, {31'd0, Busy}, 32'd0);
  endtask

  task automatic wr(input logic [3:0] op, input logic [31:0] d);
    MDUOp = op; MDUIn1 = d;
    step();
    MDUOp = 4'd0;
  endtask

  initial begin
    reset = 1'b1; MDUOp = 4'd0; Start = 1'b0; MDUIn1 = '0; MDUIn2 = '0;
    step(); step();
    reset = 1'b0;
    chk("rst.busy", {31'd0, Busy}, 32'd0);
    rd("rst", 32'h0, 32'h0);
    chk("none.res", MDURes, 32'h0);

    // Start with a non-MD opcode must not launch anything
    MDUOp = 4'd5; Start = 1'b1; step();
    Start = 1'b0; MDUOp = 4'd0;
    chk("startmf.busy", {31'd0, Busy}, 32'd0);

    run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 5);
    rd("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);

    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5);
    rd("multu", 32'h00000001, 32'hFFFFFFFE);

    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
    rd("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    run_op("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 10);
    rd("divu", 32'h00000001, 32'h7FFFFFFC);

    wr(4'd7, 32'h00001234);
    rd("mthi", 32'h00001234, 32'h7FFFFFFC);
    run_op("div0", 4'd4, 32'd5, 32'd0, 10);
    rd("div0", 32'h00001234, 32'h7FFFFFFC);

    wr(4'd8, 32'h00005678);
    rd("mtlo", 32'h00001234, 32'h00005678);

    // mult 7*6 with mthi and a div launch attempted while busy
    MDUOp = 4'd1; Start = 1'b1; MDUIn1 = 32'd7; MDUIn2 = 32'd6;
    step();
    MDUOp = 4'd0; Start = 1'b0;
    chk("ovl.b1", {31'd0, Busy}, 32'd1);
    step();
    wr(4'd7, 32'h0000AAAA);
    rd("ovl.mid", 32'h00001234, 32'h00005678);
    MDUOp = 4'd3; Start = 1'b1; MDUIn1 = 32'd100; MDUIn2 = 32'd3;
    step();
    MDUOp = 4'd0; Start = 1'b0;
    chk("ovl.b4", {31'd0, Busy}, 32'd1);
    step();
    chk("ovl.b5", {31'd0, Busy}, 32'd1);
    step();
    chk("ovl.done", {31'd0, Busy}, 32'd0);
    rd("ovl", 32'h00000000, 32'h0000002A);
    step(); step();
    chk("ovl.idle", {31'd0, Busy}, 32'd0);

    // reset on Busy cycle 3 of a mult aborts it
    wr(4'd7, 32'h11111111);
    MDUOp = 4'd1; Start = 1'b1; MDUIn1 = 32'd3; MDUIn2 = 32'd3;
    step();
    MDUOp = 4'd0; Start = 1'b0;
    step(); step();
    chk("abort.b3", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.busy", {31'd0, Busy}, 32'd0);
    rd("abort", 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) step();
    chk("abort.late", {31'd0, Busy}, 32'd0);
    rd("abort.late", 32'h0, 32'h0);

    run_op("divmin", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    rd("divmin", 32'h00000000, 32'h80000000);

    run_op("divneg", 4'd3, 32'd7, 32'hFFFFFFFE, 10);
    rd("divneg", 32'h00000001, 32'hFFFFFFFD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
